calc_ctrl: RTL
==============

CALC_CTRL -- requirements
Module: calc_ctrl

Interface
REQ-001 SHALL provide parameter WIDTH, default 16, operand/accumulator width.
REQ-002 SHALL provide parameter TIMEOUT, default 15, max cycles waiting for alu_done.
REQ-003 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous active-high reset.
REQ-005 SHALL have ports btn_a, btn_b, btn_c  input  1 each  op-select levels, sampled on exec.
REQ-006 SHALL have ports btn_exec, btn_clr  input  1 each  raw button levels, rising-edge triggered.
REQ-007 SHALL have port operand  input  WIDTH  second operand, sampled on exec.
REQ-008 SHALL have ports alu_req  output  1, alu_op  output  4, alu_a/alu_b  output  WIDTH  ALU issue.
REQ-009 SHALL have ports alu_done  input  1, alu_result  input  WIDTH, alu_ovf  input  1  ALU return.
REQ-010 SHALL have ports acc  output  WIDTH, busy/done/zero/ovf/err  output  1 each  status.

Function
REQ-011 SHALL detect rising edges of btn_exec/btn_clr with a registered previous-value, one cycle detection latency.
REQ-012 SHALL map {btn_a,btn_b,btn_c} to alu_op: 000->0x2, 001->0x0, 010->0xD, 011->0x9, 100->0x4, 101->0x1, 110->0x7, 111->0xA.
REQ-013 SHALL implement FSM IDLE, ISSUE, WAIT, WB; busy=1 in every state except IDLE.
REQ-014 IDLE: on exec edge latch op code and operand, go ISSUE; otherwise stay.
REQ-015 ISSUE: drive alu_req=1 exactly one cycle with alu_a=acc, alu_b=latched operand, alu_op=latched code; go WAIT.
REQ-016 alu_a/alu_b/alu_op SHALL hold latched values from ISSUE through WB; alu_req=0 outside ISSUE.
REQ-017 WAIT: on alu_done go WB capturing alu_result/alu_ovf; count cycles, on TIMEOUT cycles without alu_done set err, go IDLE, acc unchanged.
REQ-018 WB: write acc=alu_result, zero=(alu_result==0), pulse done one cycle, go IDLE.
REQ-019 Exec edge while busy SHALL be dropped, not queued.
REQ-020 Clr edge in any state SHALL set acc=0, zero=1, ovf=0, err=0, go IDLE; clr wins over simultaneous exec or alu_done.
REQ-021 alu_done outside WAIT SHALL be ignored.

Reset
REQ-022 rst SHALL force IDLE, acc=0, zero=1, ovf=0, err=0, done=0, alu_req=0, alu_op=0, alu_a=alu_b=0, timeout counter=0, edge registers=0.
REQ-023 rst asserted mid-operation SHALL abort it; a late alu_done after rst SHALL have no effect.

Configuration
REQ-024 Macro CALC_OVF_HOLD_EN defined: alu_ovf=1 in WB SHALL leave acc unchanged, set ovf sticky until clr/rst, still pulse done.
REQ-025 CALC_OVF_HOLD_EN undefined: acc SHALL be written regardless; ovf SHALL equal alu_ovf of the last WB.

Structure
REQ-026 Package calc_pkg SHALL hold FSM state typedef, 4-bit op-code constants and the button-to-op table.
REQ-027 Op mapping SHALL be sub-module calc_op_map (combinational, 3 in/4 out); rest in calc_ctrl.

Verification
REQ-028 rst, acc=0; exec with abc=100, operand=5, ALU returns 5 after 2 cycles -> alu_req one cycle with alu_op=0x4, alu_b=5; acc=5, done one pulse, zero=0.
REQ-029 exec while busy (second edge during WAIT) -> exactly one alu_req, acc updated once.
REQ-030 no alu_done for 15 cycles -> err=1, busy=0, acc unchanged; next exec runs normally.
REQ-031 clr and alu_done same cycle in WAIT -> acc=0, zero=1, no done pulse.
REQ-032 alu_ovf=1 with result 0x1234, acc=0x0007 -> with macro: acc=0x0007, ovf=1 held; without: acc=0x1234, ovf=1 until next WB.
REQ-033 sweep all 8 abc combinations -> alu_op matches REQ-012 table.

Source files
------------

// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared types and op-code table for the calculator controller
//
// Purpose : FSM state type, 4-bit ALU op-code constants and the
//           {btn_a,btn_b,btn_c} -> alu_op lookup table.
// Ports   : none (package)
package calc_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_WB    = 2'd3
   } state_t;

   // Op codes named after the button pattern that selects them.
   localparam logic [3:0] OP_ABC_000 = 4'h2;
   localparam logic [3:0] OP_ABC_001 = 4'h0;
   localparam logic [3:0] OP_ABC_010 = 4'hD;
   localparam logic [3:0] OP_ABC_011 = 4'h9;
   localparam logic [3:0] OP_ABC_100 = 4'h4;
   localparam logic [3:0] OP_ABC_101 = 4'h1;
   localparam logic [3:0] OP_ABC_110 = 4'h7;
   localparam logic [3:0] OP_ABC_111 = 4'hA;

   // Entry [i] is the op code for {btn_a,btn_b,btn_c} == i.
   localparam logic [7:0][3:0] OP_TABLE = {
      OP_ABC_111, OP_ABC_110, OP_ABC_101, OP_ABC_100,
      OP_ABC_011, OP_ABC_010, OP_ABC_001, OP_ABC_000
   };

   function automatic logic [3:0] op_lookup(input logic [2:0] abc);
      return OP_TABLE[abc];
   endfunction

endpackage

// File: rtl/calc_op_map.sv
// rtl/calc_op_map.sv - combinational button-to-op-code mapper
//
// Purpose : translate the three op-select button levels into an ALU op code.
// Ports   : abc_i [2:0] {btn_a,btn_b,btn_c}
//           op_o  [3:0] ALU op code
module calc_op_map
   import calc_pkg::*;
(
   input  logic [2:0] abc_i,
   output logic [3:0] op_o
);

   assign op_o = op_lookup(abc_i);

endmodule

// File: rtl/calc_ctrl.sv
// rtl/calc_ctrl.sv - button-driven accumulator controller issuing requests to an external ALU
//
// Purpose : edge-detect exec/clr buttons, issue one ALU request per exec,
//           wait (with timeout) for the result and write it to the accumulator.
// Ports   : clk, rst (sync, active high)
//           btn_a/b/c     op-select levels      btn_exec/btn_clr raw button levels
//           operand       second operand
//           alu_req/alu_op/alu_a/alu_b          ALU issue
//           alu_done/alu_result/alu_ovf         ALU return
//           acc, busy, done, zero, ovf, err     status
// Config  : CALC_OVF_HOLD_EN - when defined, an overflowing result leaves acc
//           unchanged and sets a sticky ovf flag.
module calc_ctrl
   import calc_pkg::*;
#(
   parameter int WIDTH   = 16,
   parameter int TIMEOUT = 15
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             btn_a,
   input  logic             btn_b,
   input  logic             btn_c,
   input  logic             btn_exec,
   input  logic             btn_clr,
   input  logic [WIDTH-1:0] operand,
   output logic             alu_req,
   output logic [3:0]       alu_op,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   input  logic             alu_done,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_ovf,
   output logic [WIDTH-1:0] acc,
   output logic             busy,
   output logic             done,
   output logic             zero,
   output logic             ovf,
   output logic             err
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   state_t           state_q, state_d;
   logic             exec_prev_q, clr_prev_q;
   logic [3:0]       op_q, op_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             rovf_q, rovf_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic             zero_q, zero_d;
   logic             ovf_q, ovf_d;
   logic             err_q, err_d;
   logic             done_q, done_d;
   logic [3:0]       op_sel;
   logic             exec_edge, clr_edge;

   calc_op_map u_op_map (
      .abc_i ({btn_a, btn_b, btn_c}),
      .op_o  (op_sel)
   );

   assign exec_edge = btn_exec & ~exec_prev_q;
   assign clr_edge  = btn_clr  & ~clr_prev_q;

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      rovf_d  = rovf_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      zero_d  = zero_q;
      ovf_d   = ovf_q;
      err_d   = err_q;
      done_d  = 1'b0;

      // Clear preempts everything, including a result arriving this cycle.
      if (clr_edge) begin
         state_d = ST_IDLE;
         acc_d   = '0;
         zero_d  = 1'b1;
         ovf_d   = 1'b0;
         err_d   = 1'b0;
         cnt_d   = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               // Exec edges outside IDLE fall through untouched, so they are dropped.
               if (exec_edge) begin
                  op_d    = op_sel;
                  a_d     = acc_q;
                  b_d     = operand;
                  state_d = ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               cnt_d   = '0;
               state_d = ST_WAIT;
            end
            ST_WAIT: begin
               if (alu_done) begin
                  res_d   = alu_result;
                  rovf_d  = alu_ovf;
                  state_d = ST_WB;
               end else if (cnt_q == CNT_LAST) begin
                  err_d   = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            ST_WB: begin
               done_d  = 1'b1;
               state_d = ST_IDLE;
`ifdef CALC_OVF_HOLD_EN
               if (rovf_q) begin
                  ovf_d = 1'b1;
               end else begin
                  acc_d  = res_q;
                  zero_d = (res_q == '0);
               end
`else
               acc_d  = res_q;
               zero_d = (res_q == '0);
               ovf_d  = rovf_q;
`endif
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         exec_prev_q <= 1'b0;
         clr_prev_q  <= 1'b0;
         op_q        <= '0;
         a_q         <= '0;
         b_q         <= '0;
         res_q       <= '0;
         rovf_q      <= 1'b0;
         cnt_q       <= '0;
         acc_q       <= '0;
         zero_q      <= 1'b1;
         ovf_q       <= 1'b0;
         err_q       <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         exec_prev_q <= btn_exec;
         clr_prev_q  <= btn_clr;
         op_q        <= op_d;
         a_q         <= a_d;
         b_q         <= b_d;
         res_q       <= res_d;
         rovf_q      <= rovf_d;
         cnt_q       <= cnt_d;
         acc_q       <= acc_d;
         zero_q      <= zero_d;
         ovf_q       <= ovf_d;
         err_q       <= err_d;
         done_q      <= done_d;
      end
   end

   assign alu_req = (state_q == ST_ISSUE);
   assign alu_op  = op_q;
   assign alu_a   = a_q;
   assign alu_b   = b_q;
   assign acc     = acc_q;
   assign busy    = (state_q != ST_IDLE);
   assign done    = done_q;
   assign zero    = zero_q;
   assign ovf     = ovf_q;
   assign err     = err_q;

endmodule
